// File: rtl/bcd_serial_add_ctrl_pkg.sv
// bcd_serial_add_ctrl_pkg: shared BCD constants and sequencer state type
package bcd_serial_add_ctrl_pkg;
  localparam int BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int PAIR_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// bcd_serial_add_ctrl_if: start/busy/done handshake, operands and result of the serial BCD adder
interface bcd_serial_add_ctrl_if #(parameter int DIGITS = 8);
  localparam int W = 4 * DIGITS;
  logic start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic cin;
  logic busy;
  logic done;
  logic [W-1:0] sum;
  logic cout;
  logic err;
  modport master(output start, a, b, cin, input busy, done, sum, cout, err);
  modport slave(input start, a, b, cin, output busy, done, sum, cout, err);
endinterface

// File: rtl/bcd_serial_add_ctrl_bcd8.sv
// bcd_serial_add_ctrl_bcd8: two-digit packed-BCD adder with decimal carry in/out
module bcd_serial_add_ctrl_bcd8
  import bcd_serial_add_ctrl_pkg::*;
(
  input  logic [PAIR_W-1:0] a,
  input  logic [PAIR_W-1:0] b,
  input  logic              cin,
  output logic [PAIR_W-1:0] sum,
  output logic              cout
);
  logic [4:0] lo_raw, hi_raw;
  logic lo_c;
  assign lo_raw = {1'b0, a[3:0]} + {1'b0, b[3:0]} + {4'b0, cin};
  assign lo_c   = lo_raw > 5'd9;
  assign hi_raw = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, lo_c};
  assign cout   = hi_raw > 5'd9;
  assign sum    = {hi_raw[3:0] + (cout ? 4'd6 : 4'd0), lo_raw[3:0] + (lo_c ? 4'd6 : 4'd0)};
endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: adds DIGITS-digit packed-BCD operands one digit pair per clock through a single bcd8
module bcd_serial_add_ctrl
  import bcd_serial_add_ctrl_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input logic clk,
  input logic rst,
  bcd_serial_add_ctrl_if.slave bus
);
  localparam int W = 4 * DIGITS;
  localparam int NPASS = DIGITS / 2;
  localparam int CW = NPASS > 1 ? $clog2(NPASS) : 1;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0] op_a, op_b, sum_q;
  logic carry, cout_q, err_q, bad, accept, last;
  logic [PAIR_W-1:0] pair_sum;
  logic pair_cout;
  bcd_serial_add_ctrl_bcd8 u_bcd8 (
    .a(op_a[PAIR_W-1:0]),
    .b(op_b[PAIR_W-1:0]),
    .cin(carry),
    .sum(pair_sum),
    .cout(pair_cout)
  );
  assign accept = state != RUN && bus.start;
  assign last   = cnt == CW'(NPASS - 1);
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (bus.a[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX)
                | (bus.b[i*BCD_DIGIT_W +: BCD_DIGIT_W] > BCD_MAX);
  end
  always_comb begin
    nxt = state;
    nxt = state == RUN ? (last ? DONE : RUN) : (bus.start ? RUN : (state == DONE ? IDLE : state));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state <= nxt;
      if (accept) begin
        op_a   <= bus.a;
        op_b   <= bus.b;
        carry  <= bus.cin;
        cnt    <= '0;
        sum_q  <= '0;
        cout_q <= 1'b0;
        err_q  <= bad;
      end else if (state == RUN) begin
        // result pairs enter at the top so the LS pair lands at bit 0 after NPASS shifts
        sum_q <= {pair_sum, sum_q[W-1:PAIR_W]};
        op_a  <= op_a >> PAIR_W;
        op_b  <= op_b >> PAIR_W;
        carry <= pair_cout;
        cnt   <= cnt + 1'b1;
        if (last) cout_q <= pair_cout;
      end
    end
  end
  assign bus.busy = state == RUN;
  assign bus.done = state == DONE;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.err  = err_q;
endmodule
